// File: rtl/loc_safe_pkg.sv
// Shared types and helpers for the LIFO location safe: op decode and width helpers.
package loc_safe_pkg;

    localparam int unsigned LOC_W_DEF = 8;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_STORE,
        OP_RESTORE,
        OP_REPLACE,
        OP_CLEAR
    } loc_op_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic loc_op_t loc_op_decode(input logic clear, input logic store,
                                              input logic restore);
        if (clear)                return OP_CLEAR;
        else if (store && restore) return OP_REPLACE;
        else if (store)            return OP_STORE;
        else if (restore)          return OP_RESTORE;
        else                       return OP_NOP;
    endfunction

endpackage

// File: rtl/loc_safe_mem.sv
// DEPTH x LOC_W register array: one synchronous write port, combinational read port(s).
// A second read port exists when LOC_SAFE_PEEK_EN is defined.
module loc_safe_mem
    import loc_safe_pkg::*;
#(
    parameter int unsigned LOC_W = LOC_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [LOC_W-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
`ifdef LOC_SAFE_PEEK_EN
    input  logic [PTR_W-1:0] praddr_i,
    output logic [LOC_W-1:0] prdata_o,
`endif
    output logic [LOC_W-1:0] rdata_o
);

    logic [LOC_W-1:0] mem_q [DEPTH];
    logic [LOC_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[waddr_i] = wdata_i;
    end

    // No reset: contents are only observable through valid entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

`ifdef LOC_SAFE_PEEK_EN
    assign prdata_o = mem_q[praddr_i];
`endif

endmodule

// File: rtl/loc_safe_stack.sv
// LIFO stack of saved locations with registered top-of-stack and sticky error flags.
// Optional peek port enabled by defining LOC_SAFE_PEEK_EN.
module loc_safe_stack
    import loc_safe_pkg::*;
#(
    parameter int unsigned LOC_W     = LOC_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LOC_W-1:0]              loc_i,
    input  logic                          store_i,
    input  logic                          restore_i,
    input  logic                          clear_i,
`ifdef LOC_SAFE_PEEK_EN
    input  logic [ptr_width(DEPTH)-1:0]   peek_idx_i,
    output logic [LOC_W-1:0]              peek_o,
`endif
    output logic [LOC_W-1:0]              loc_o,
    output logic                          valid_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [PtrW-1:0]  tp_q, tp_d, waddr, raddr;
    logic [CntW-1:0]  count_q, count_d;
    logic [LOC_W-1:0] loc_q, loc_d, rdata;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             we, full, empty;
    loc_op_t          op;

    assign op    = loc_op_decode(clear_i, store_i, restore_i);
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign raddr = tp_q - 1'b1;

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        loc_d   = loc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = tp_q + 1'b1;
        unique case (op)
            OP_CLEAR: begin
                count_d = '0;
                loc_d   = '0;
            end
            OP_STORE, OP_REPLACE: begin
                if (op == OP_REPLACE && !empty) begin
                    we    = 1'b1;
                    waddr = tp_q;
                    loc_d = loc_i;
                end else if (!full || OVERWRITE != 0) begin
                    // When full with overwrite, tp+1 is the oldest slot.
                    we      = 1'b1;
                    tp_d    = tp_q + 1'b1;
                    count_d = full ? count_q : count_q + 1'b1;
                    loc_d   = loc_i;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OP_RESTORE: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    tp_d    = tp_q - 1'b1;
                    count_d = count_q - 1'b1;
                    loc_d   = (count_q == CntW'(1)) ? '0 : rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_q    <= PtrW'(DEPTH - 1);
            count_q <= '0;
            loc_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            loc_q   <= loc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef LOC_SAFE_PEEK_EN
    logic [LOC_W-1:0] peek_rd;

    loc_safe_mem #(
        .LOC_W (LOC_W),
        .DEPTH (DEPTH),
        .PTR_W (PtrW)
    ) u_mem (
        .clk      (clk),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (loc_i),
        .raddr_i  (raddr),
        .praddr_i (tp_q - peek_idx_i),
        .prdata_o (peek_rd),
        .rdata_o  (rdata)
    );

    assign peek_o = ({1'b0, peek_idx_i} < count_q) ? peek_rd : '0;
`else
    loc_safe_mem #(
        .LOC_W (LOC_W),
        .DEPTH (DEPTH),
        .PTR_W (PtrW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (loc_i),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );
`endif

    assign loc_o       = loc_q;
    assign count_o     = count_q;
    assign valid_o     = !empty;
    assign full_o      = full;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_loc_safe_stack.sv
// Bench for loc_safe_stack: OVERWRITE=0 and OVERWRITE=1 instances share stimulus and are
// checked every cycle against an array model; directed sequences pin literal values.
module tb_loc_safe_stack;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, clear_i, store_i, restore_i;
    logic [7:0] loc_i;
    logic [1:0] peek_idx_i;

    logic [7:0] loc_o       [2];
    logic       valid_o     [2];
    logic [2:0] count_o     [2];
    logic       full_o      [2];
    logic       overflow_o  [2];
    logic       underflow_o [2];
    logic [7:0] peek_o      [2];

    always #5 clk = ~clk;

`ifdef LOC_SAFE_PEEK_EN
    loc_safe_stack #(.LOC_W(8), .DEPTH(D), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst(rst), .loc_i(loc_i), .store_i(store_i), .restore_i(restore_i),
        .clear_i(clear_i), .peek_idx_i(peek_idx_i), .peek_o(peek_o[0]), .loc_o(loc_o[0]),
        .valid_o(valid_o[0]), .count_o(count_o[0]), .full_o(full_o[0]),
        .overflow_o(overflow_o[0]), .underflow_o(underflow_o[0]));
    loc_safe_stack #(.LOC_W(8), .DEPTH(D), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst(rst), .loc_i(loc_i), .store_i(store_i), .restore_i(restore_i),
        .clear_i(clear_i), .peek_idx_i(peek_idx_i), .peek_o(peek_o[1]), .loc_o(loc_o[1]),
        .valid_o(valid_o[1]), .count_o(count_o[1]), .full_o(full_o[1]),
        .overflow_o(overflow_o[1]), .underflow_o(underflow_o[1]));
`else
    loc_safe_stack #(.LOC_W(8), .DEPTH(D), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst(rst), .loc_i(loc_i), .store_i(store_i), .restore_i(restore_i),
        .clear_i(clear_i), .loc_o(loc_o[0]), .valid_o(valid_o[0]), .count_o(count_o[0]),
        .full_o(full_o[0]), .overflow_o(overflow_o[0]), .underflow_o(underflow_o[0]));
    loc_safe_stack #(.LOC_W(8), .DEPTH(D), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst(rst), .loc_i(loc_i), .store_i(store_i), .restore_i(restore_i),
        .clear_i(clear_i), .loc_o(loc_o[1]), .valid_o(valid_o[1]), .count_o(count_o[1]),
        .full_o(full_o[1]), .overflow_o(overflow_o[1]), .underflow_o(underflow_o[1]));
    assign peek_o[0] = '0;
    assign peek_o[1] = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Model: m[k][0] is the oldest entry, m[k][sz[k]-1] the top.
    int         sz [2];
    logic [7:0] m  [2][D];
    bit         mo [2];
    bit         mu [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            sz[k] = 0; mo[k] = 0; mu[k] = 0;
            for (int j = 0; j < D; j++) m[k][j] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                sz[k] = 0; mo[k] = 0; mu[k] = 0;
            end else if (clear_i) begin
                sz[k] = 0;
            end else if (store_i && restore_i && sz[k] > 0) begin
                m[k][sz[k]-1] = loc_i;
            end else if (store_i) begin
                if (sz[k] < D) begin
                    m[k][sz[k]] = loc_i;
                    sz[k]++;
                end else if (k == 1) begin
                    for (int j = 0; j < D - 1; j++) m[k][j] = m[k][j+1];
                    m[k][D-1] = loc_i;
                end else begin
                    mo[k] = 1;
                end
            end else if (restore_i) begin
                if (sz[k] == 0) mu[k] = 1;
                else sz[k]--;
            end
        end
    end

    function automatic logic [7:0] exp_top(input int k);
        return (sz[k] > 0) ? m[k][sz[k]-1] : 8'd0;
    endfunction

    function automatic logic [7:0] exp_peek(input int k, input int idx);
        return (idx < sz[k]) ? m[k][sz[k]-1-idx] : 8'd0;
    endfunction

    // Per-cycle compare against the model.
    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check("loc_o",       k, 32'(loc_o[k]),       32'(exp_top(k)));
                check("count_o",     k, 32'(count_o[k]),     32'(sz[k]));
                check("valid_o",     k, 32'(valid_o[k]),     32'(sz[k] > 0));
                check("full_o",      k, 32'(full_o[k]),      32'(sz[k] == D));
                check("overflow_o",  k, 32'(overflow_o[k]),  32'(mo[k]));
                check("underflow_o", k, 32'(underflow_o[k]), 32'(mu[k]));
`ifdef LOC_SAFE_PEEK_EN
                check("peek_o",      k, 32'(peek_o[k]),      32'(exp_peek(k, int'(peek_idx_i))));
`endif
            end
        end
    end

    task automatic cyc(input bit r, input bit c, input bit s, input bit rs, input logic [7:0] l);
        rst = r; clear_i = c; store_i = s; restore_i = rs; loc_i = l;
        @(negedge clk);
    endtask

    initial begin
        rst = 1; clear_i = 0; store_i = 0; restore_i = 0; loc_i = 0; peek_idx_i = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_count", 0, 32'(count_o[0]), 0);
        check("rst_loc",   0, 32'(loc_o[0]),   0);
        check("rst_valid", 0, 32'(valid_o[0]), 0);

        // Store 44, 70, 90 then restore past empty.
        cyc(0, 0, 1, 0, 44); check("st44", 0, 32'(loc_o[0]), 44);
        cyc(0, 0, 1, 0, 70); check("st70", 0, 32'(loc_o[0]), 70);
        cyc(0, 0, 1, 0, 90); check("st90", 0, 32'(loc_o[0]), 90);
        check("cnt3",   0, 32'(count_o[0]), 3);
        check("valid3", 0, 32'(valid_o[0]), 1);
        check("full3",  0, 32'(full_o[0]),  0);
        cyc(0, 0, 0, 1, 0); check("rs1_loc", 0, 32'(loc_o[0]), 70);
        check("rs1_cnt", 0, 32'(count_o[0]), 2);
        cyc(0, 0, 0, 1, 0); check("rs2_loc", 0, 32'(loc_o[0]), 44);
        check("rs2_cnt", 0, 32'(count_o[0]), 1);
        cyc(0, 0, 0, 1, 0); check("rs3_loc", 0, 32'(loc_o[0]), 0);
        check("rs3_cnt", 0, 32'(count_o[0]), 0);
        cyc(0, 0, 0, 1, 0); check("rs4_loc", 0, 32'(loc_o[0]), 0);
        check("rs4_cnt", 0, 32'(count_o[0]), 0);
        check("rs4_unf", 0, 32'(underflow_o[0]), 1);

        // Store 1..5 into both policies, then drain.
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 0, 8'(i));
        check("ow0_cnt",  0, 32'(count_o[0]),    4);
        check("ow0_full", 0, 32'(full_o[0]),     1);
        check("ow0_loc",  0, 32'(loc_o[0]),      4);
        check("ow0_ovf",  0, 32'(overflow_o[0]), 1);
        check("ow1_loc",  1, 32'(loc_o[1]),      5);
        check("ow1_cnt",  1, 32'(count_o[1]),    4);
        check("ow1_ovf",  1, 32'(overflow_o[1]), 0);
        begin
            logic [7:0] e0 [4];
            logic [7:0] e1 [4];
            e0 = '{8'd3, 8'd2, 8'd1, 8'd0};
            e1 = '{8'd4, 8'd3, 8'd2, 8'd0};
            for (int i = 0; i < 4; i++) begin
                cyc(0, 0, 0, 1, 0);
                check("ow0_drain", 0, 32'(loc_o[0]), 32'(e0[i]));
                check("ow1_drain", 1, 32'(loc_o[1]), 32'(e1[i]));
            end
        end

        // Replace, clear-with-store, then reset clears sticky flags.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 23);
        cyc(0, 0, 1, 1, 100);
        check("repl_loc", 0, 32'(loc_o[0]),   100);
        check("repl_cnt", 0, 32'(count_o[0]), 1);
        cyc(0, 1, 1, 0, 55);
        check("clr_cnt", 0, 32'(count_o[0]), 0);
        check("clr_loc", 0, 32'(loc_o[0]),   0);
        cyc(0, 0, 0, 1, 0);
        check("unf_set", 0, 32'(underflow_o[0]), 1);
        cyc(1, 0, 1, 0, 9);
        check("rst_unf", 0, 32'(underflow_o[0]), 0);
        check("rst_ovf", 0, 32'(overflow_o[0]),  0);
        check("rst_win", 0, 32'(count_o[0]),     0);

`ifdef LOC_SAFE_PEEK_EN
        cyc(0, 0, 1, 0, 10);
        cyc(0, 0, 1, 0, 20);
        cyc(0, 0, 1, 0, 30);
        cyc(0, 0, 0, 0, 0);
        begin
            logic [7:0] ep [4];
            ep = '{8'd30, 8'd20, 8'd10, 8'd0};
            for (int i = 0; i < 4; i++) begin
                peek_idx_i = 2'(i);
                #2;
                check("peek", 0, 32'(peek_o[0]), 32'(ep[i]));
            end
        end
        @(negedge clk);
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            peek_idx_i = 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 8'($urandom));
        end
        cyc(0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/loc_safe_stack.md
# loc_safe_stack

Parametrised successor to the single-entry location safe in the RC4/Sobel datapath. Holds up to DEPTH saved locations in LIFO order so that nested search loops (key-schedule retries, Sobel window backtracking) can store a location, descend, and restore it later. Sits beside the controller FSM: the controller issues store/restore/clear strobes, and the datapath reads the top-of-stack location.

## Interface
Parameters:
- LOC_W, 8, width of a stored location
- DEPTH, 4, number of entries (power of two, ≥2)
- OVERWRITE, 0, full-stack store policy: 0 rejects the store and flags overflow; 1 discards the oldest entry

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- loc_i  in  LOC_W  location to save
- store_i  in  1  push loc_i
- restore_i  in  1  pop top entry
- clear_i  in  1  empty the stack; highest priority
- loc_o  out  LOC_W  registered top-of-stack value; 0 when empty
- valid_o  out  1  stack non-empty
- count_o  out  $clog2(DEPTH)+1  number of valid entries
- full_o  out  1  count_o == DEPTH
- overflow_o  out  1  sticky, rejected store (OVERWRITE=0 only)
- underflow_o  out  1  sticky, restore while empty

## Operation
- Storage is a circular array with a top pointer (tp) and a saturating count. A push writes at tp+1 and advances tp. A pop decrements tp.
- Priority per cycle: rst > clear_i > {store_i, restore_i}.
- clear_i: count←0, loc_o←0, valid_o←0. Sticky flags are kept. Array contents are don't-care.
- Store only, not full: push. count+1. loc_o←loc_i.
- Store only, full, OVERWRITE=1: push over the oldest slot (tp wraps). count stays DEPTH. loc_o←loc_i.
- Store only, full, OVERWRITE=0: no change to array or count. overflow_o←1.
- Restore only, count>1: pop. count−1. loc_o←new top entry.
- Restore only, count==1: pop. count←0. loc_o←0.
- Restore only, empty: no change. underflow_o←1.
- Store and restore together, non-empty: replace the top entry with loc_i. count unchanged. loc_o←loc_i. No flags.
- Store and restore together, empty: treat as store only.
- Sticky flags clear only on rst.
- Pointer arithmetic is modulo DEPTH. count is never allowed to exceed DEPTH or go below 0.

## Timing
- All outputs are registered. Every effect is visible on the clk edge following the strobe (latency 1). There is no combinational path from inputs to outputs.
- Back-to-back strobes are legal every cycle. There is no handshake or stall.
- Reset values: loc_o=0, valid_o=0, count_o=0, full_o=0, overflow_o=0, underflow_o=0, tp=DEPTH−1.
- Reset asserted mid-sequence wins over any strobe in the same cycle. Outputs take reset values on the next edge.
- full_o and valid_o are derived from the registered count in the same cycle as count_o.

## Configuration
- LOC_SAFE_PEEK_EN defined:
  - adds input peek_idx_i ($clog2(DEPTH) bits) and output peek_o (LOC_W bits).
  - peek_o = entry at depth peek_idx_i below the top (0 = top), as a combinational read of the array.
  - peek_o = 0 when peek_idx_i ≥ count_o.
- LOC_SAFE_PEEK_EN undefined: neither port exists, and the array has a single read port feeding loc_o.

## Structure
- Package loc_safe_pkg:
  - enum loc_op_t {OP_NOP, OP_STORE, OP_RESTORE, OP_REPLACE, OP_CLEAR}
  - decode function from {clear_i, store_i, restore_i}
  - localparams for pointer and count widths
- Sub-module loc_safe_mem:
  - DEPTH×LOC_W register array
  - one synchronous write port and one read port, plus a second read port under LOC_SAFE_PEEK_EN
  - synchronous reset is not applied to the array itself
- Top module: op decode, tp/count registers, loc_o register, sticky flags.

## Test plan
All tests use LOC_W=8, DEPTH=4.
- Reset, then store 44, 70, 90 on consecutive cycles → loc_o 44/70/90 one cycle after each; count_o=3; valid_o=1; full_o=0.
- From that state, restore ×3 → loc_o 70, 44, 0; count_o 2, 1, 0. A fourth restore → no change to loc_o or count_o; underflow_o=1.
- OVERWRITE=0: store 1, 2, 3, 4, 5 → count_o=4, full_o=1, loc_o=4, overflow_o=1. Restore ×4 → 3, 2, 1, 0.
- OVERWRITE=1: store 1..5 → loc_o=5, count_o=4. Restore ×4 → 4, 3, 2, 0 (entry 1 discarded). No overflow_o.
- Store 23, then store 100 with restore 1 in the same cycle → loc_o=100, count_o=1. Then clear_i with store_i in the same cycle → count_o=0, loc_o=0. Then rst → both sticky flags read 0.
- LOC_SAFE_PEEK_EN: store 10, 20, 30 → peek_idx_i 0/1/2/3 gives 30/20/10/0.
